// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared dcache coherence types (MSI state, address split, snoop FSM states).
package cpu_types_pkg;
    localparam int DC_IDX_W = 3;
    localparam int DC_TAG_W = 26;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        M = 2'b10
    } msi_t;

    typedef struct packed {
        logic [DC_TAG_W-1:0] tag;
        logic [DC_IDX_W-1:0] idx;
        logic                off;
        logic [1:0]          bsel;
    } dcache_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        SUPPLY0,
        SUPPLY1,
        RELEASE,
        UPDATE
    } snoop_state_t;
endpackage

// File: rtl/snoop_hit_detect.sv
// snoop_hit_detect: two-way tag match of a snooped tag against one dcache set.
module snoop_hit_detect
    import cpu_types_pkg::*;
#(
    parameter int TAG_W = 26
) (
    input  logic [TAG_W-1:0] tag_i,
    input  logic [TAG_W-1:0] tag0_i,
    input  logic [TAG_W-1:0] tag1_i,
    input  logic [1:0]       st0_i,
    input  logic [1:0]       st1_i,
    output logic             hit_o,
    output logic             way_o,
    output logic             mod_o,
    output logic             dual_o
);
    logic hit0, hit1;

    assign hit0   = tag0_i == tag_i && msi_t'(st0_i) != I;
    assign hit1   = tag1_i == tag_i && msi_t'(st1_i) != I;
    assign hit_o  = hit0 || hit1;
    // Way 0 wins a double hit; that case is an illegal cache state.
    assign way_o  = !hit0 && hit1;
    assign mod_o  = hit0 ? msi_t'(st0_i) == M : hit1 && msi_t'(st1_i) == M;
    assign dual_o = hit0 && hit1;
endmodule

// File: rtl/dcache_snoop_responder.sv
// dcache_snoop_responder: answers controller snoops for one L1 dcache, supplies
// Modified blocks word by word and applies the resulting MSI downgrade/invalidate.
module dcache_snoop_responder
    import cpu_types_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int TAG_W = 26
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ccwait,
    input  logic [31:0]      ccsnoopaddr,
    input  logic             ccinv,
    input  logic             xfer_ack,
    output logic             cctrans,
    output logic             ccwrite,
    output logic [31:0]      snoop_dstore,
    output logic             snoop_stall,
    output logic [IDX_W-1:0] lk_idx,
    output logic             lk_way,
    output logic             lk_off,
    input  logic [TAG_W-1:0] lk_tag0,
    input  logic [TAG_W-1:0] lk_tag1,
    input  logic [1:0]       lk_st0,
    input  logic [1:0]       lk_st1,
    input  logic [31:0]      lk_data,
    output logic             upd_en,
    output logic [IDX_W-1:0] upd_idx,
    output logic             upd_way,
    output logic [1:0]       upd_st
);
    snoop_state_t     state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             way_q, way_d, hit_q, hit_d, mod_q, mod_d, inv_q, inv_d, done_q, done_d;
    logic             idle, supply, hit, way, modd, dual;
    logic [TAG_W-1:0] snoop_tag;

    assign idle      = state_q == IDLE;
    assign supply    = state_q == SUPPLY0 || state_q == SUPPLY1;
    assign snoop_tag = idle ? ccsnoopaddr[31:32-TAG_W] : tag_q;
    assign lk_idx    = idle ? ccsnoopaddr[IDX_W+2:3] : idx_q;

    snoop_hit_detect #(.TAG_W(TAG_W)) u_hit (
        .tag_i  (snoop_tag),
        .tag0_i (lk_tag0),
        .tag1_i (lk_tag1),
        .st0_i  (lk_st0),
        .st1_i  (lk_st1),
        .hit_o  (hit),
        .way_o  (way),
        .mod_o  (modd),
        .dual_o (dual)
    );

    // Snoop answer is zero-latency in IDLE, then held from the latched lookup.
    assign cctrans      = nRST && ccwait && (idle ? hit : hit_q);
    assign ccwrite      = nRST && ccwait && (idle ? modd : mod_q);
    assign snoop_stall  = nRST && (!idle || ccwait);
    assign lk_way       = way_q;
    assign lk_off       = state_q == SUPPLY1;
    assign snoop_dstore = supply ? lk_data : '0;
    assign upd_en       = state_q == UPDATE;
    assign upd_idx      = upd_en ? idx_q : '0;
    assign upd_way      = upd_en && way_q;
    assign upd_st       = upd_en ? (inv_q ? I : S) : I;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        way_d   = way_q;
        hit_d   = hit_q;
        mod_d   = mod_q;
        inv_d   = inv_q | (!idle && ccwait && ccinv);
        done_d  = done_q;
        case (state_q)
            IDLE: if (ccwait) begin
                tag_d   = snoop_tag;
                idx_d   = lk_idx;
                way_d   = way;
                hit_d   = hit;
                mod_d   = modd;
                inv_d   = ccinv;
                done_d  = 1'b0;
                state_d = modd ? SUPPLY0 : RELEASE;
            end
            SUPPLY0: state_d = !ccwait ? IDLE : xfer_ack ? SUPPLY1 : SUPPLY0;
            SUPPLY1: if (!ccwait) begin
                state_d = IDLE;
            end else if (xfer_ack) begin
                state_d = RELEASE;
                done_d  = 1'b1;
            end
            RELEASE: if (!ccwait) state_d = hit_q ? UPDATE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            way_q   <= 1'b0;
            hit_q   <= 1'b0;
            mod_q   <= 1'b0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            hit_q   <= hit_d;
            mod_q   <= mod_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
        end
    end

    a_no_dual_hit: assert property (@(posedge CLK) disable iff (!nRST) idle && ccwait |-> !dual)
        else $error("snooped block valid in both ways");
    a_supplied_before_release: assert property (@(posedge CLK) disable iff (!nRST)
        state_q == RELEASE && mod_q |-> done_q)
        else $error("Modified block released without full supply");
endmodule

// File: tb/tb_dcache_snoop_responder.sv
// tb_dcache_snoop_responder: directed vector table, reset corner and randomized snoops
// checked against a transaction-level model of the dcache set contents.
module tb_dcache_snoop_responder;
    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    logic        CLK = 1'b0, nRST = 1'b0, ccwait = 1'b0, ccinv = 1'b0, xfer_ack = 1'b0;
    logic [31:0] ccsnoopaddr = '0;
    logic        cctrans, ccwrite, snoop_stall, lk_way, lk_off, upd_en, upd_way;
    logic [31:0] snoop_dstore, lk_data;
    logic [2:0]  lk_idx, upd_idx;
    logic [25:0] lk_tag0, lk_tag1;
    logic [1:0]  lk_st0, lk_st1, upd_st;

    logic [25:0] ctag [8][2];
    logic [1:0]  cst  [8][2];
    logic [31:0] cdat [8][2][2];

    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [31:0] a;
        logic [25:0] t0, t1;
        logic [1:0]  s0, s1;
        logic [7:0]  inv;
        logic        ab, et, ew, ewy;
        logic [1:0]  est;
    } vec_t;
    vec_t vt [8];

    logic [2:0]  r_ix;
    logic [25:0] r_t;
    logic [7:0]  r_inv;
    logic        r_h0, r_h1, r_hw, r_ew, r_ab;
    logic [1:0]  r_est;

    always #5 CLK = ~CLK;

    assign lk_tag0 = ctag[lk_idx][0];
    assign lk_tag1 = ctag[lk_idx][1];
    assign lk_st0  = cst[lk_idx][0];
    assign lk_st1  = cst[lk_idx][1];
    assign lk_data = cdat[lk_idx][lk_way][lk_off];

    dcache_snoop_responder dut (
        .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr), .ccinv(ccinv),
        .xfer_ack(xfer_ack), .cctrans(cctrans), .ccwrite(ccwrite), .snoop_dstore(snoop_dstore),
        .snoop_stall(snoop_stall), .lk_idx(lk_idx), .lk_way(lk_way), .lk_off(lk_off),
        .lk_tag0(lk_tag0), .lk_tag1(lk_tag1), .lk_st0(lk_st0), .lk_st1(lk_st1), .lk_data(lk_data),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_way(upd_way), .upd_st(upd_st)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // One whole snoop transaction; ack_wait idle cycles precede each ack, rel_n cycles held in release.
    task automatic snoop(input logic [31:0] a, input logic [7:0] inv, input logic abort, input int ack_wait,
                         input int rel_n, input logic et, input logic ew, input logic ewy, input logic [1:0] est);
        logic [2:0]  ix;
        logic [31:0] wd [2];
        logic        ab;
        int          k;
        ix    = a[5:3];
        wd[0] = cdat[ix][ewy][0];
        wd[1] = cdat[ix][ewy][1];
        ab    = 1'b0;
        k     = 0;
        @(negedge CLK);
        ccwait      = 1'b1;
        ccsnoopaddr = a;
        ccinv       = inv[0];
        xfer_ack    = 1'($urandom);
        #1;
        chk("cctrans_snoop", cctrans, et);
        chk("ccwrite_snoop", ccwrite, ew);
        chk("lk_idx_snoop", lk_idx, ix);
        chk("stall_snoop", snoop_stall, 1);
        chk("dstore_snoop", snoop_dstore, 0);
        if (ew) begin
            for (int w = 0; w < 2; w++) begin
                for (int j = 0; j <= ack_wait; j++) begin
                    if (!ab) begin
                        k++;
                        @(negedge CLK);
                        ab       = abort && w == 1 && j == ack_wait;
                        ccwait   = !ab;
                        ccinv    = !ab && k < 8 && inv[k[2:0]];
                        xfer_ack = j == ack_wait;
                        #1;
                        chk("dstore_supply", snoop_dstore, wd[w]);
                        chk("lk_off_supply", 32'(lk_off), 32'(w));
                        chk("lk_way_supply", lk_way, ewy);
                        chk("lk_idx_supply", lk_idx, ix);
                        chk("ccwrite_supply", ccwrite, !ab);
                        chk("stall_supply", snoop_stall, 1);
                        chk("upd_en_supply", upd_en, 0);
                    end
                end
            end
        end
        if (!ab) begin
            for (int r = 0; r < rel_n; r++) begin
                k++;
                @(negedge CLK);
                ccinv    = k < 8 && inv[k[2:0]];
                xfer_ack = 1'($urandom);
                #1;
                chk("cctrans_release", cctrans, et);
                chk("ccwrite_release", ccwrite, ew);
                chk("dstore_release", snoop_dstore, 0);
                chk("upd_en_release", upd_en, 0);
                chk("stall_release", snoop_stall, 1);
            end
            @(negedge CLK);
            ccwait   = 1'b0;
            ccinv    = 1'b0;
            xfer_ack = 1'b0;
            #1;
            chk("cctrans_drop", cctrans, 0);
            chk("stall_drop", snoop_stall, 1);
            chk("upd_en_drop", upd_en, 0);
            if (et) begin
                @(negedge CLK);
                #1;
                chk("upd_en", upd_en, 1);
                chk("upd_idx", upd_idx, ix);
                chk("upd_way", upd_way, ewy);
                chk("upd_st", upd_st, est);
                chk("stall_update", snoop_stall, 1);
                if (upd_en) cst[upd_idx][upd_way] = upd_st;
            end
        end
        xfer_ack = 1'b0;
        @(negedge CLK);
        #1;
        chk("upd_en_idle", upd_en, 0);
        chk("stall_idle", snoop_stall, 0);
        chk("cctrans_idle", cctrans, 0);
        chk("final_state", 32'(cst[ix][ewy]), 32'(est));
    endtask

    initial begin
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                ctag[s][w]    = '0;
                cst[s][w]     = ST_I;
                cdat[s][w][0] = '0;
                cdat[s][w][1] = '0;
            end
        end
        vt[0] = '{32'h0000_1234, 26'h10, 26'h10, ST_S, ST_S, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ST_S};
        vt[1] = '{32'h0000_1234, 26'h10, 26'h48, ST_S, ST_S, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, ST_S};
        vt[2] = '{32'h0000_1234, 26'h48, 26'h10, ST_M, ST_S, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, ST_S};
        vt[3] = '{32'h0000_1234, 26'h48, 26'h10, ST_M, ST_S, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, ST_I};
        vt[4] = '{32'h0000_1234, 26'h48, 26'h10, ST_M, ST_S, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, ST_M};
        vt[5] = '{32'h0000_1234, 26'h48, 26'h10, ST_S, ST_S, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, ST_I};
        vt[6] = '{32'h0000_1234, 26'h48, 26'h48, ST_I, ST_I, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ST_I};
        vt[7] = '{32'hABCD_EF38, 26'h1, 26'h2AF37BC, ST_M, ST_M, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, ST_I};

        #1;
        chk("rst_cctrans", cctrans, 0);
        chk("rst_ccwrite", ccwrite, 0);
        chk("rst_stall", snoop_stall, 0);
        chk("rst_dstore", snoop_dstore, 0);
        chk("rst_upd_en", upd_en, 0);
        chk("rst_upd_st", upd_st, 0);
        chk("rst_lk_off", lk_off, 0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 8; i++) begin
            r_ix = vt[i].a[5:3];
            ctag[r_ix][0]    = vt[i].t0;
            ctag[r_ix][1]    = vt[i].t1;
            cst[r_ix][0]     = vt[i].s0;
            cst[r_ix][1]     = vt[i].s1;
            cdat[r_ix][0][0] = 32'hDEAD_BEEF;
            cdat[r_ix][0][1] = 32'hCAFE_F00D;
            cdat[r_ix][1][0] = 32'h1111_2222;
            cdat[r_ix][1][1] = 32'h3333_4444;
            snoop(vt[i].a, vt[i].inv, vt[i].ab, 1, 2, vt[i].et, vt[i].ew, vt[i].ewy, vt[i].est);
        end

        // Reset asserted while the first word of a Modified block is on snoop_dstore.
        ctag[6][0] = 26'h48;
        cst[6][0]  = ST_M;
        ctag[6][1] = 26'h10;
        cst[6][1]  = ST_S;
        @(negedge CLK);
        ccwait      = 1'b1;
        ccsnoopaddr = 32'h0000_1234;
        ccinv       = 1'b0;
        xfer_ack    = 1'b0;
        #1;
        chk("mid_rst_ccwrite", ccwrite, 1);
        @(negedge CLK);
        #1;
        chk("mid_rst_dstore_before", snoop_dstore, 32'hDEAD_BEEF);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_cctrans", cctrans, 0);
        chk("mid_rst_ccwrite0", ccwrite, 0);
        chk("mid_rst_dstore", snoop_dstore, 0);
        chk("mid_rst_stall", snoop_stall, 0);
        chk("mid_rst_upd_en", upd_en, 0);
        chk("mid_rst_lk_off", lk_off, 0);
        @(negedge CLK);
        ccwait = 1'b0;
        nRST   = 1'b1;
        @(negedge CLK);
        #1;
        chk("post_rst_upd_en", upd_en, 0);
        chk("post_rst_stall", snoop_stall, 0);
        snoop(32'h0000_1234, 8'h00, 1'b0, 0, 2, 1'b1, 1'b1, 1'b0, ST_S);

        for (int n = 0; n < 80; n++) begin
            r_ix = 3'($urandom);
            r_t  = 26'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int w = 0; w < 2; w++) begin
                    ctag[r_ix][w]    = 26'($urandom_range(0, 3));
                    cst[r_ix][w]     = 2'($urandom_range(0, 2));
                    cdat[r_ix][w][0] = $urandom;
                    cdat[r_ix][w][1] = $urandom;
                end
                if (ctag[r_ix][0] == ctag[r_ix][1] && cst[r_ix][0] != ST_I && cst[r_ix][1] != ST_I)
                    cst[r_ix][1] = ST_I;
            end
            r_h0  = ctag[r_ix][0] == r_t && cst[r_ix][0] != ST_I;
            r_h1  = ctag[r_ix][1] == r_t && cst[r_ix][1] != ST_I;
            r_hw  = !r_h0 && r_h1;
            r_ew  = (r_h0 || r_h1) && cst[r_ix][r_hw] == ST_M;
            r_inv = 8'($urandom_range(0, 7));
            r_ab  = r_ew && $urandom_range(0, 3) == 0;
            r_est = (r_h0 || r_h1) && !r_ab ? (r_inv != 0 ? ST_I : ST_S) : cst[r_ix][r_hw];
            snoop({r_t, r_ix, 3'($urandom)}, r_inv, r_ab, $urandom_range(0, 2), $urandom_range(2, 3),
                  r_h0 || r_h1, r_ew, r_hw, r_est);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dcache_snoop_responder.md
Name: dcache_snoop_responder

Overview:
- Cache-side end of the coherence protocol; one instance per core, next to that core's L1 dcache.
- Answers memory-controller snoops on ccwait/ccsnoopaddr and reports hit/modified on cctrans/ccwrite.
- On a Modified hit, supplies the two-word block word by word.
- Applies the resulting MSI downgrade or invalidate to the dcache state array.
- Dcache geometry: 2-way, 2-word blocks.

Parameters:
IDX_W, 3, set index width (8 sets)
TAG_W, 26, tag width (32 - IDX_W - 1 block-offset bit - 2 byte bits)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
ccwait  in  1  controller snoop request; held high for whole snoop transaction
ccsnoopaddr  in  32  snooped byte address, valid while ccwait=1
ccinv  in  1  requester has write intent; sampled every cycle ccwait=1
xfer_ack  in  1  controller accepted current supplied word (per-word handshake)
cctrans  out  1  snooped block present (state S or M)
ccwrite  out  1  snooped block Modified
snoop_dstore  out  32  supplied block word
snoop_stall  out  1  dcache must not access/modify frame arrays this cycle
lk_idx  out  IDX_W  lookup set index
lk_way  out  1  data-read way select
lk_off  out  1  data-read word select
lk_tag0, lk_tag1  in  TAG_W  tags of set lk_idx
lk_st0, lk_st1  in  2  msi_t state of set lk_idx
lk_data  in  32  data word at (lk_idx, lk_way, lk_off), combinational
upd_en  out  1  state write strobe
upd_idx  out  IDX_W  update set
upd_way  out  1  update way
upd_st  out  2  new msi_t state

Behaviour:
- Address split: tag=[31:6], idx=[5:3], off=[2], byte=[1:0].
- Reset: FSM=IDLE, latched addr/way/flags=0. All outputs 0 (snoop_stall=0, upd_en=0).
- Hit detection: way w hits if lk_tagw==tag and lk_stw!=I. Way 0 has priority if both hit; this is an illegal state, flagged by assertion.
- FSM states: IDLE, SUPPLY0, SUPPLY1, RELEASE, UPDATE.
- IDLE:
  - lk_idx = ccsnoopaddr idx, combinational.
  - If ccwait=1: cctrans=hit and ccwrite=hit&&M combinationally in the same cycle (zero latency; the controller samples them in its snoop cycle).
  - On ccwait=1, latch tag/idx/way/hit/M, set inv_sticky=ccinv, done=0.
  - Next state: hit&&M -> SUPPLY0, else RELEASE.
- All non-IDLE states:
  - lk_idx = latched idx; cctrans/ccwrite driven from latched flags while ccwait=1, 0 otherwise.
  - inv_sticky |= ccinv each cycle ccwait=1.
- SUPPLY0: lk_way=latched way, lk_off=0, snoop_dstore=lk_data.
  - xfer_ack -> SUPPLY1.
  - ccwait=0 -> abort to IDLE, no state change (dirty data preserved).
- SUPPLY1: lk_off=1.
  - xfer_ack -> RELEASE, done=1.
  - ccwait=0 -> abort to IDLE.
- RELEASE: wait for ccwait=0.
  - Then, if hit -> UPDATE, else IDLE.
- UPDATE: one cycle, upd_en=1 at latched idx/way, then IDLE.
  - upd_st = inv_sticky ? I : S (M downgrades to S, S stays S).
- snoop_dstore = 0 outside SUPPLY0/1.
- snoop_stall = (state!=IDLE) || ccwait.
- xfer_ack outside SUPPLY0/1 is ignored.
- xfer_ack together with ccwait=0: abort wins.
- ccwait re-asserted in the UPDATE cycle: ignored until IDLE. Controller guarantees ≥1 idle cycle between snoops.
- nRST low mid-transaction: immediate return to IDLE, no update issued.

Decomposition:
- cpu_types_pkg gains:
  - msi_t enum: I=2'b00, S=2'b01, M=2'b10.
  - dcache_addr_t packed struct: tag/idx/off/byte.
  - snoop_state_t enum.
- One combinational sub-module, snoop_hit_detect: tags/states/tag in -> hit, way, modified.

Test Plan:
- Miss: ccwait=1, addr 0x0000_1234 (idx 6, tag 0x48), both ways tag 0x10 -> cctrans=0, ccwrite=0 same cycle; on ccwait drop no upd_en; back to IDLE.
- S hit, read: way1 tag 0x48 state S, ccinv=0 -> cctrans=1, ccwrite=0, no data; after ccwait drop, upd_en one cycle with upd_st=S, way1, idx 6.
- M hit, read: way0 M, data {0xDEADBEEF,0xCAFEF00D} -> cctrans=ccwrite=1. snoop_dstore=0xDEADBEEF until xfer_ack, then 0xCAFEF00D. After second ack and ccwait drop: upd_st=S.
- M hit, write intent: as above, ccinv=1 asserted only in second cycle -> final upd_st=I (sticky capture).
- Abort: M hit, ccwait dropped in SUPPLY1 before xfer_ack -> no upd_en, state remains M, FSM IDLE next cycle.
- Reset mid-SUPPLY0: nRST pulse -> all outputs 0 immediately, no upd_en; next snoop handled normally.
